// File: rtl/line_buffer_3x3.sv
// Row buffer for a 3x3 window: keeps the two previous rows of a square raster frame
// and emits the vertically aligned column triple (rows r-2, r-1, r) for every pixel.
module line_buffer_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic [8:0]            IMG_SIZE_I,
    output logic [DATA_WIDTH-1:0] S1_o,
    output logic [DATA_WIDTH-1:0] S2_o,
    output logic [DATA_WIDTH-1:0] S3_o,
    output logic                  data_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] line_a [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] line_b [MAX_WIDTH];

    logic [8:0]  col, row;
    logic [9:0]  size_m1;
    logic        accept;
    logic        last_col;
    logic        last_row;

    logic signed [DATA_WIDTH-1:0] unused_sign_p0;
    logic [DATA_WIDTH-1:0] s1_p1, s2_p1, s3_p1;
    logic                  vld_p1;

    // Widened to 10 bits so a size of zero cannot wrap the last-index compare.
    assign size_m1  = {1'b0, IMG_SIZE_I} - 10'd1;
    assign last_col = ({1'b0, col} == size_m1);
    assign last_row = ({1'b0, row} == size_m1);
    assign accept   = ((state == FILL) || (state == STREAM)) && data_valid_i && !start_i;
    assign unused_sign_p0 = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_i) state_nxt = FILL;
            FILL: begin
                if (start_i)
                    state_nxt = FILL;
                else if (accept && last_col && (row == 9'd1))
                    state_nxt = STREAM;
            end
            STREAM: begin
                if (start_i)
                    state_nxt = FILL;
                else if (accept && last_col && last_row)
                    state_nxt = DONE;
            end
            DONE:   state_nxt = start_i ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            FILL, STREAM: busy_o = 1'b1;
            DONE:         done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (start_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= row + 9'd1;
            end else begin
                col <= col + 9'd1;
            end
        end
    end

    // Line memories are never cleared: every column is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_b[col] <= line_a[col];
            line_a[col] <= data_i;
        end
    end

    // Stage p0 -> p1: register the column triple and its strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_p1  <= '0;
            s2_p1  <= '0;
            s3_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept && (state == STREAM);
            if (accept) begin
                s1_p1 <= line_b[col];
                s2_p1 <= line_a[col];
                s3_p1 <= data_i;
            end
        end
    end

    assign S1_o         = s1_p1;
    assign S2_o         = s2_p1;
    assign S3_o         = s3_p1;
    assign data_valid_o = vld_p1;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench for line_buffer_3x3: the driver predicts each column triple,
// a negedge monitor pops and compares whenever data_valid_o is high.
module tb_line_buffer_3x3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic [8:0] img_size;
    logic [7:0] s1, s2, s3;
    logic       dv, busy, done;

    typedef struct {
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   errors = 0;
    int   checks = 0;
    int   vcount = 0;
    int   dcount = 0;

    always #5 clk = ~clk;

    line_buffer_3x3 #(.DATA_WIDTH(8), .MAX_WIDTH(512)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .IMG_SIZE_I   (img_size),
        .S1_o         (s1),
        .S2_o         (s2),
        .S3_o         (s3),
        .data_valid_o (dv),
        .busy_o       (busy),
        .done_o       (done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) dcount++;
        if (dv === 1'b1) begin
            vcount++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got %0d/%0d/%0d done=%0b, expected no output",
                         s1, s2, s3, done);
            end else begin
                e_mon = sb.pop_front();
                if ({s1, s2, s3, done} !== {e_mon.s1, e_mon.s2, e_mon.s3, e_mon.done}) begin
                    errors++;
                    $display("FAIL triple got %0d/%0d/%0d done=%0b, expected %0d/%0d/%0d done=%0b",
                             s1, s2, s3, done, e_mon.s1, e_mon.s2, e_mon.s3, e_mon.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired, simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int n, input int base, input int r, input int c);
        pix = 8'(base + n * r + c);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input int base, input int r, input int c);
        exp_t e;
        e.s1   = pix(n, base, r - 2, c);
        e.s2   = pix(n, base, r - 1, c);
        e.s3   = pix(n, base, r, c);
        e.done = (r == n - 1) && (c == n - 1);
        sb.push_back(e);
    endtask

    // Start pulse carries a valid junk pixel that must be dropped.
    task automatic pulse_start();
        start_i      = 1'b1;
        data_valid_i = 1'b1;
        data_i       = 8'hA5;
        cyc();
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        checks++;
        if (busy !== 1'b1 || dv !== 1'b0) begin
            errors++;
            $display("FAIL after_start busy=%0b dv=%0b, expected busy=1 dv=0", busy, dv);
        end
    endtask

    task automatic drive_frame(input int n, input int base, input bit do_start, input bit gaps);
        logic [7:0] h1, h2, h3;
        img_size = 9'(n);
        if (do_start) pulse_start();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (gaps) begin
                    h1 = s1; h2 = s2; h3 = s3;
                    data_valid_i = 1'b0;
                    data_i       = 8'hEE;
                    cyc();
                    checks++;
                    if (dv !== 1'b0 || s1 !== h1 || s2 !== h2 || s3 !== h3) begin
                        errors++;
                        $display("FAIL gap_hold got dv=%0b %0d/%0d/%0d, expected dv=0 %0d/%0d/%0d",
                                 dv, s1, s2, s3, h1, h2, h3);
                    end
                end
                data_i       = pix(n, base, r, c);
                data_valid_i = 1'b1;
                if (r >= 2) push_exp(n, base, r, c);
                cyc();
            end
        end
        data_valid_i = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end done=%0b busy=%0b, expected done=1 busy=0", done, busy);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dv !== 1'b0) begin
            errors++;
            $display("FAIL after_done done=%0b busy=%0b dv=%0b, expected 0/0/0", done, busy, dv);
        end
    endtask

    task automatic check_counts(input string name, input int v0, input int d0,
                                input int vexp, input int dexp);
        checks++;
        if (vcount - v0 !== vexp || dcount - d0 !== dexp || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_counts valid=%0d done=%0d pending=%0d, expected valid=%0d done=%0d pending=0",
                     name, vcount - v0, dcount - d0, sb.size(), vexp, dexp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; data_valid_i = 1'b0; data_i = 8'h00; img_size = 9'd4;
        cyc();
        cyc();
        checks++;
        if (s1 !== 8'd0 || s2 !== 8'd0 || s3 !== 8'd0) begin
            errors++;
            $display("FAIL reset_data got %0d/%0d/%0d, expected 0/0/0", s1, s2, s3);
        end
        checks++;
        if (dv !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl dv=%0b busy=%0b done=%0b, expected 0/0/0", dv, busy, done);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_continuous();
        int v0 = vcount, d0 = dcount;
        drive_frame(4, 0, 1'b1, 1'b0);
        check_counts("continuous", v0, d0, 8, 1);
    endtask

    task automatic test_gaps();
        int v0 = vcount, d0 = dcount;
        drive_frame(4, 0, 1'b1, 1'b1);
        check_counts("gaps", v0, d0, 8, 1);
    endtask

    task automatic test_back_to_back();
        int v0 = vcount, d0 = dcount;
        drive_frame(4, 0, 1'b1, 1'b0);
        drive_frame(4, 100, 1'b1, 1'b0);
        check_counts("back_to_back", v0, d0, 16, 2);
    endtask

    task automatic test_abort();
        int v0, d0;
        img_size = 9'd5;
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            data_i       = pix(5, 0, i / 5, i % 5);
            data_valid_i = 1'b1;
            if (i == 10) push_exp(5, 0, 2, 0);
            cyc();
        end
        start_i      = 1'b1;
        data_i       = pix(5, 0, 2, 1);
        cyc();
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        checks++;
        if (dv !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle dv=%0b busy=%0b, expected dv=0 busy=1", dv, busy);
        end
        v0 = vcount;
        d0 = dcount;
        drive_frame(5, 0, 1'b0, 1'b0);
        check_counts("abort", v0, d0, 15, 1);
    endtask

    task automatic test_reset_mid();
        int v0;
        img_size = 9'd4;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            data_i       = pix(4, 0, i / 4, i % 4);
            data_valid_i = 1'b1;
            if (i >= 8) push_exp(4, 0, 2, i % 4);
            cyc();
        end
        rst_n = 1'b0;
        data_i = pix(4, 0, 2, 2);
        cyc();
        rst_n = 1'b1;
        checks++;
        if (s1 !== 8'd0 || s2 !== 8'd0 || s3 !== 8'd0 || dv !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %0d/%0d/%0d dv=%0b busy=%0b done=%0b, expected all 0",
                     s1, s2, s3, dv, busy, done);
        end
        v0 = vcount;
        for (int i = 0; i < 8; i++) begin
            data_i       = 8'(i + 50);
            data_valid_i = 1'b1;
            cyc();
        end
        data_valid_i = 1'b0;
        cyc();
        checks++;
        if (vcount !== v0 || busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL no_start_pixels valid=%0d busy=%0b pending=%0d, expected 0/0/0",
                     vcount - v0, busy, sb.size());
        end
    endtask

    task automatic test_size3();
        int v0 = vcount, d0 = dcount;
        drive_frame(3, 0, 1'b1, 1'b0);
        check_counts("size3", v0, d0, 3, 1);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_size3();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
